// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: the fetch exception
// triple and the 67-bit entry stored per queue slot.
package fetch_queue_pkg;

  // Fetch exception flags, MSB first: {AdEL, TLBRefill, TLBInvalid}.
  typedef struct packed {
    logic adel;
    logic tlb_refill;
    logic tlb_invalid;
  } FetchExceptType;

  // One buffered fetch result.
  typedef struct packed {
    logic [31:0]    pc;
    logic [31:0]    instr;
    FetchExceptType exc;
  } fq_entry_t;

  localparam int FQ_ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/fetch_queue_ram.sv
// DEPTH x 67-bit storage for the fetch queue: one synchronous write
// port and one asynchronous read port. No reset; contents are only
// meaningful where the owning queue says an entry is valid.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  fq_entry_t     wr_data,
  input  logic [AW-1:0] rd_addr,
  output fq_entry_t     rd_data
);

  fq_entry_t mem [DEPTH];

  // Write the pushed entry into its slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the I-cache response path and IF/ID.
//
// Handshake: PreIF may assert Icache_Req only in a cycle where Req_Ready
// is 1; each accepted request reserves one queue slot until its response
// returns, so a non-dropped response always finds space. Icache_Valid is
// a one-cycle response strobe with no back-pressure. ID_Wr pops the head
// when IF_Valid is 1 and is ignored when the queue is empty. IF_Flush
// empties the queue and arms a drop counter so responses of the old
// stream still in flight are discarded when they arrive.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           IF_Flush,
  input  logic           Icache_Req,
  output logic           Req_Ready,
  input  logic           Icache_Valid,
  input  logic [31:0]    Icache_PC,
  input  logic [31:0]    Icache_Instr,
  input  FetchExceptType Icache_ExceptType,
  input  logic           ID_Wr,
  output logic           IF_Valid,
  output logic [31:0]    IF_PC,
  output logic [31:0]    IF_Instr,
  output FetchExceptType IF_ExceptType,
  output logic           Buf_Overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [OUT_W-1:0] out_cnt, drop_cnt;
  logic             overflow_q;

  logic      empty, full, pop, accept, push, overflow_next;
  fq_entry_t wr_data, rd_data;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  // Flush takes priority over both pop and push.
  assign pop    = ID_Wr && !empty && !IF_Flush;
  // A response is a candidate for the queue unless it belongs to the old stream.
  assign accept = Icache_Valid && !IF_Flush && (drop_cnt == '0);
  // A full queue can still take a push when the head leaves the same cycle.
  assign push   = accept && (!full || pop);
  assign overflow_next = accept && full && !pop;

  assign Req_Ready = (32'(out_cnt) < MAX_OUTSTANDING) &&
                     ((32'(out_cnt) + 32'(count)) < DEPTH);

  assign wr_data = '{pc: Icache_PC, instr: Icache_Instr, exc: Icache_ExceptType};

  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (tail),
    .wr_data (wr_data),
    .rd_addr (head),
    .rd_data (rd_data)
  );

  // Queue pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (IF_Flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // In-flight request tracking and old-stream drop accounting.
  // Decrements clamp at zero so a stray response cannot wrap the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (Icache_Req && !Icache_Valid) begin
        out_cnt <= out_cnt + 1'b1;
      end else if (!Icache_Req && Icache_Valid && (out_cnt != '0)) begin
        out_cnt <= out_cnt - 1'b1;
      end

      if (IF_Flush) begin
        // Everything outstanding now belongs to the old stream, except a
        // response arriving this very cycle, which is discarded directly.
        drop_cnt <= (Icache_Valid && (out_cnt != '0)) ? out_cnt - 1'b1 : out_cnt;
      end else if (Icache_Valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // Registered overflow pulse, one cycle after the offending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_next;
  end

  assign Buf_Overflow = overflow_q;

  // Present the head entry, or zero/nop when the queue is empty.
  always_comb begin
    IF_Valid      = !empty;
    IF_PC         = 32'h0;
    IF_Instr      = 32'h0;
    IF_ExceptType = '0;
    if (!empty) begin
      IF_PC         = rd_data.pc;
      IF_Instr      = rd_data.instr;
      IF_ExceptType = rd_data.exc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a hand-derived vector table covering the main
// scenarios and corner cases, an asynchronous reset check, then random
// traffic compared against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           IF_Flush, Icache_Req, Icache_Valid, ID_Wr;
  logic [31:0]    Icache_PC, Icache_Instr;
  FetchExceptType Icache_ExceptType;
  logic           Req_Ready, IF_Valid, Buf_Overflow;
  logic [31:0]    IF_PC, IF_Instr;
  FetchExceptType IF_ExceptType;
  logic [2:0]     if_exc_bits;

  assign if_exc_bits = IF_ExceptType;

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk               (clk),
    .rst               (rst),
    .IF_Flush          (IF_Flush),
    .Icache_Req        (Icache_Req),
    .Req_Ready         (Req_Ready),
    .Icache_Valid      (Icache_Valid),
    .Icache_PC         (Icache_PC),
    .Icache_Instr      (Icache_Instr),
    .Icache_ExceptType (Icache_ExceptType),
    .ID_Wr             (ID_Wr),
    .IF_Valid          (IF_Valid),
    .IF_PC             (IF_PC),
    .IF_Instr          (IF_Instr),
    .IF_ExceptType     (IF_ExceptType),
    .Buf_Overflow      (Buf_Overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- vector table ----------------
  typedef struct {
    logic        flush, req, resp;
    logic [31:0] pc, instr;
    logic [2:0]  exc;
    logic        id_wr;
    logic        ev;
    logic [31:0] epc, einstr;
    logic [2:0]  eexc;
    logic        erdy, eovf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic fl, logic rq, logic rs, logic [31:0] pc,
                              logic [31:0] ins, logic [2:0] exc, logic idw,
                              logic ev, logic [31:0] epc, logic [31:0] eins,
                              logic [2:0] eexc, logic erdy, logic eovf);
    vec_t v;
    v.flush = fl; v.req = rq; v.resp = rs; v.pc = pc; v.instr = ins;
    v.exc = exc; v.id_wr = idw; v.ev = ev; v.epc = epc; v.einstr = eins;
    v.eexc = eexc; v.erdy = erdy; v.eovf = eovf;
    return v;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic ev, logic [31:0] epc,
                            logic [31:0] eins, logic [2:0] eexc,
                            logic erdy, logic eovf);
    check({tag, " IF_Valid"},      32'(IF_Valid),     32'(ev));
    check({tag, " IF_PC"},         IF_PC,             epc);
    check({tag, " IF_Instr"},      IF_Instr,          eins);
    check({tag, " IF_ExceptType"}, 32'(if_exc_bits),  32'(eexc));
    check({tag, " Req_Ready"},     32'(Req_Ready),    32'(erdy));
    check({tag, " Buf_Overflow"},  32'(Buf_Overflow), 32'(eovf));
  endtask

  task automatic drive(logic fl, logic rq, logic rs, logic [31:0] pc,
                       logic [31:0] ins, logic [2:0] exc, logic idw);
    IF_Flush = fl; Icache_Req = rq; Icache_Valid = rs;
    Icache_PC = pc; Icache_Instr = ins; Icache_ExceptType = exc; ID_Wr = idw;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0, 3'b000, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  fq_entry_t mq[$];
  int        m_out, m_drop;
  logic      m_ovf;

  task automatic model_reset();
    mq.delete(); m_out = 0; m_drop = 0; m_ovf = 1'b0;
  endtask

  function automatic logic model_ready();
    return (m_out < MAXO) && (m_out + mq.size() < DEPTH);
  endfunction

  task automatic model_step(logic fl, logic rq, logic rs, fq_entry_t e, logic idw);
    logic popped;
    m_ovf = 1'b0;
    if (fl) begin
      mq.delete();
      m_drop = (m_out - int'(rs) < 0) ? 0 : m_out - int'(rs);
    end else begin
      popped = idw && (mq.size() > 0);
      if (popped) void'(mq.pop_front());
      if (rs) begin
        if (m_drop > 0)                          m_drop--;
        else if (mq.size() < DEPTH)              mq.push_back(e);
        else                                     m_ovf = 1'b1;
      end
    end
    m_out = m_out + int'(rq) - int'(rs);
    if (m_out < 0) m_out = 0;
  endtask

  task automatic model_check(string tag);
    if (mq.size() > 0)
      check_outs(tag, 1'b1, mq[0].pc, mq[0].instr, mq[0].exc, model_ready(), m_ovf);
    else
      check_outs(tag, 1'b0, 32'h0, 32'h0, 3'b000, model_ready(), m_ovf);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    localparam logic [31:0] JPC = 32'hDEAD0000;
    localparam logic [31:0] JIN = 32'hDEADBEEF;
    vec_t v;
    fq_entry_t e;
    logic fl, rq, rs, idw;

    // single request/response, pop
    vq.push_back(mk(0,1,0, 0,0,0, 0,  0, 0,0,0, 1,0));
    vq.push_back(mk(0,0,1, 32'hBFC00000,32'h24080001,0, 0,  1, 32'hBFC00000,32'h24080001,0, 1,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,  0, 0,0,0, 1,0));
    // fill without popping
    vq.push_back(mk(0,1,0, 0,0,0, 0,  0, 0,0,0, 1,0));
    vq.push_back(mk(0,1,0, 0,0,0, 0,  0, 0,0,0, 0,0));
    vq.push_back(mk(0,0,1, 32'h100,32'h11,0, 0,  1, 32'h100,32'h11,0, 1,0));
    vq.push_back(mk(0,1,1, 32'h104,32'h12,0, 0,  1, 32'h100,32'h11,0, 1,0));
    vq.push_back(mk(0,1,1, 32'h108,32'h13,0, 0,  1, 32'h100,32'h11,0, 0,0));
    vq.push_back(mk(0,0,1, 32'h10C,32'h14,0, 0,  1, 32'h100,32'h11,0, 0,0));
    // push and pop together while full: no overflow, head advances
    vq.push_back(mk(0,0,1, 32'h110,32'h15,0, 1,  1, 32'h104,32'h12,0, 0,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,  1, 32'h108,32'h13,0, 1,0));
    vq.push_back(mk(1,0,0, 0,0,0, 0,  0, 0,0,0, 1,0));
    // two in flight, flush, both responses dropped, then new stream
    vq.push_back(mk(0,1,0, 0,0,0, 0,  0, 0,0,0, 1,0));
    vq.push_back(mk(0,1,0, 0,0,0, 0,  0, 0,0,0, 0,0));
    vq.push_back(mk(1,0,0, 0,0,0, 0,  0, 0,0,0, 0,0));
    vq.push_back(mk(0,0,1, JPC,JIN,0, 0,  0, 0,0,0, 1,0));
    vq.push_back(mk(0,1,1, JPC,JIN,0, 0,  0, 0,0,0, 1,0));
    vq.push_back(mk(0,0,1, 32'h80000180,32'h3C1A8000,0, 0,  1, 32'h80000180,32'h3C1A8000,0, 1,0));
    vq.push_back(mk(0,0,0, 0,0,0, 1,  0, 0,0,0, 1,0));
    // flush coinciding with a response while two are outstanding
    vq.push_back(mk(0,1,0, 0,0,0, 0,  0, 0,0,0, 1,0));
    vq.push_back(mk(0,1,0, 0,0,0, 0,  0, 0,0,0, 0,0));
    vq.push_back(mk(1,0,1, JPC,JIN,0, 0,  0, 0,0,0, 1,0));
    vq.push_back(mk(0,0,1, JPC,JIN,0, 0,  0, 0,0,0, 1,0));
    vq.push_back(mk(0,1,0, 0,0,0, 0,  0, 0,0,0, 1,0));
    vq.push_back(mk(0,0,1, 32'h200,32'h22,0, 0,  1, 32'h200,32'h22,0, 1,0));
    // request issued in the flush cycle survives
    vq.push_back(mk(0,1,0, 0,0,0, 0,  1, 32'h200,32'h22,0, 1,0));
    vq.push_back(mk(1,1,0, 0,0,0, 0,  0, 0,0,0, 0,0));
    vq.push_back(mk(0,0,1, JPC,JIN,0, 0,  0, 0,0,0, 1,0));
    vq.push_back(mk(0,0,1, 32'h80000180,32'h3C1A8000,0, 0,  1, 32'h80000180,32'h3C1A8000,0, 1,0));
    // TLB refill exception at head, then flushed away
    vq.push_back(mk(1,0,0, 0,0,0, 0,  0, 0,0,0, 1,0));
    vq.push_back(mk(0,1,0, 0,0,0, 0,  0, 0,0,0, 1,0));
    vq.push_back(mk(0,0,1, 32'h00400000,32'h8C080000,3'b010, 0,  1, 32'h00400000,32'h8C080000,3'b010, 1,0));
    vq.push_back(mk(1,0,0, 0,0,0, 0,  0, 0,0,0, 1,0));
    // forced responses fill the queue, one more overflows
    vq.push_back(mk(0,0,1, 32'h300,32'h30,0, 0,  1, 32'h300,32'h30,0, 1,0));
    vq.push_back(mk(0,0,1, 32'h304,32'h31,0, 0,  1, 32'h300,32'h30,0, 1,0));
    vq.push_back(mk(0,0,1, 32'h308,32'h32,0, 0,  1, 32'h300,32'h30,0, 1,0));
    vq.push_back(mk(0,0,1, 32'h30C,32'h33,3'b100, 0,  1, 32'h300,32'h30,0, 0,0));
    vq.push_back(mk(0,0,1, 32'h310,32'h34,0, 0,  1, 32'h300,32'h30,0, 0,1));
    vq.push_back(mk(0,0,0, 0,0,0, 0,  1, 32'h300,32'h30,0, 0,0));

    do_reset();
    check_outs("reset", 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 1'b0);

    foreach (vq[i]) begin
      v = vq[i];
      drive(v.flush, v.req, v.resp, v.pc, v.instr, v.exc, v.id_wr);
      @(posedge clk); #1;
      drive(0, 0, 0, 32'h0, 32'h0, 3'b000, 0);
      check_outs($sformatf("vec%0d", i), v.ev, v.epc, v.einstr, v.eexc, v.erdy, v.eovf);
    end

    // asynchronous reset mid-cycle with a full queue
    #3 rst = 1'b1;
    #1 check_outs("async_rst", 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    // random traffic against the reference model
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      fl  = ($urandom_range(0, 24) == 0);
      rq  = model_ready() && ($urandom_range(0, 1) == 1);
      rs  = (m_out > 0) && ($urandom_range(0, 2) != 0);
      idw = ($urandom_range(0, 2) != 0);
      e.pc    = $urandom;
      e.instr = $urandom;
      e.exc   = 3'($urandom_range(0, 7));
      drive(fl, rq, rs, e.pc, e.instr, e.exc, idw);
      model_step(fl, rq, rs, e, idw);
      @(posedge clk); #1;
      drive(0, 0, 0, 32'h0, 32'h0, 3'b000, 0);
      model_check($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the I-cache response path and the IF/ID pipeline register. It buffers fetched {PC, instruction, fetch exception} triples, issues fetch credits to PreIF, and presents the queue head to the ID stage under control of `ID_Wr`. On `IF_Flush` (branch redirect or exception) it discards all buffered entries and every response still in flight for the old stream.

## Interface
Parameters:
- `DEPTH`, 4: queue entries, power of two, ≥2.
- `MAX_OUTSTANDING`, 2: maximum I-cache requests in flight.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `IF_Flush` in 1: discard queue and old-stream in-flight responses.
- `Icache_Req` in 1: PreIF issued a fetch this cycle; legal only when `Req_Ready`=1.
- `Req_Ready` out 1: credit available for a new request.
- `Icache_Valid` in 1: response valid this cycle.
- `Icache_PC` in 32: response PC.
- `Icache_Instr` in 32: response instruction.
- `Icache_ExceptType` in 3 (`FetchExceptType`): {AdEL, TLBRefill, TLBInvalid}.
- `ID_Wr` in 1: ID register loads this cycle (pop).
- `IF_Valid` out 1: head entry valid.
- `IF_PC` out 32: head PC, 0 when empty.
- `IF_Instr` out 32: head instruction, 32'h0 (nop) when empty.
- `IF_ExceptType` out 3: head exception, 0 when empty.
- `Buf_Overflow` out 1: one-cycle pulse when an accepted response finds no space (protocol violation).

## Operation
- State: `DEPTH` entry array, `head`/`tail` pointers (log2 DEPTH bits, wrap naturally), `count` (0..DEPTH), `out_cnt` (0..MAX_OUTSTANDING), `drop_cnt` (0..MAX_OUTSTANDING).
- `req` = `Icache_Req`; `resp` = `Icache_Valid`.
- `Req_Ready` = (`out_cnt` < MAX_OUTSTANDING) && (`out_cnt` + `count` < DEPTH). Credit scheme guarantees every non-dropped response has a slot.
- `out_cnt_next` = `out_cnt` + req − resp, including on flush cycles.
- Response handling: if `drop_cnt`>0, response discarded, `drop_cnt` decrements. Otherwise push at `tail`, `tail`++, unless full with no simultaneous pop → discarded, `Buf_Overflow`=1.
- Pop: `ID_Wr` && `count`>0 → `head`++. `ID_Wr` while empty is a no-op.
- Simultaneous push and pop: both take effect; `count` unchanged; legal when full.
- Flush (highest priority): `count`, `head`, `tail` ← 0; response in that cycle discarded; `drop_cnt` ← `out_cnt` − resp. A request issued in the flush cycle belongs to the new stream and is not dropped. A second flush while `drop_cnt`>0 recomputes by the same formula.
- Outputs are driven from the head entry when `count`>0, else the zero/nop values.

## Timing
- Push-to-visible latency: 1 cycle. A response in cycle N appears on `IF_*` in cycle N+1 when the queue was empty. No combinational bypass from `Icache_*` to `IF_*`.
- Pop is seen on the outputs in the next cycle.
- `Req_Ready` is combinational from registered state only.
- Reset (asynchronous, any cycle): `count`, `out_cnt`, `drop_cnt`, pointers ← 0. `IF_Valid`=0, `IF_PC`=0, `IF_Instr`=0, `IF_ExceptType`=0, `Buf_Overflow`=0, `Req_Ready`=1. Entry array contents are don't-care.
- `Buf_Overflow` is registered: it pulses in the cycle after the violating response.

## Structure
- `FetchExceptType` (packed struct, 3 bits) goes in `CPU_Defines.svh` beside the other pipe exception types.
- One sub-module, `fetch_queue_ram`: DEPTH×67-bit register array with one write port and one asynchronous read port. Pointers, counters and flush/drop logic stay in `fetch_queue`.

## Test plan
- Reset, then single request and response (PC 0xBFC00000, instr 0x24080001) → `IF_Valid`=1 the next cycle with matching outputs. `ID_Wr` pops it, and the queue is empty one cycle later.
- Fill with `ID_Wr`=0 → `Req_Ready` drops when `out_cnt`+`count`=4. With `ID_Wr`=1 and a response in the same full cycle, `count` stays at 4 and no overflow occurs.
- Two requests in flight, then `IF_Flush` → the next two responses are discarded. A request issued in the flush cycle (PC 0x80000180) is enqueued and appears with `IF_Valid`=1.
- Flush in the same cycle as a response, with `out_cnt`=2 → `drop_cnt`=1. Exactly one later response is discarded.
- Response with TLBRefill=1 at PC 0x00400000 → `IF_ExceptType`=3'b010 at the head. The flush behind it clears it.
- Forced response into a full queue with no pop → entry discarded, `Buf_Overflow` pulses once. Asserting `rst` mid-stream clears all outputs immediately.
